// File: rtl/pdp_mem_pkg.sv
// Shared constants and encodings for the PDP memory arbiter slice.
package pdp_mem_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 12;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; on a tie the requester that did not own the last access wins.
module rr_arb2
  import pdp_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_owner == OWN_D) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port synchronous MEMORY between instruction fetch and data access,
// sequencing one access every two cycles around the 1-cycle read latency.
module mem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy
);

  import pdp_mem_pkg::*;

  state_t            state, state_nxt;
  owner_t            owner_p0, last_owner;
  logic              we_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [1:0]        req_vec, arb_gnt;
  logic              take;
  logic              win_d;
  logic              we_nxt;

  assign req_vec = {d_req, if_req};
  assign win_d   = arb_gnt[1];
  assign we_nxt  = win_d & d_we;

  rr_arb2 u_arb (
    .req        (req_vec),
    .last_owner (last_owner),
    .gnt        (arb_gnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Grants are decided in IDLE or RESP so a new access can follow a done without a gap.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    case (state)
      S_IDLE, S_RESP: begin
        if (|req_vec && !rst) begin
          take      = 1'b1;
          if_gnt    = arb_gnt[0];
          d_gnt     = arb_gnt[1];
          state_nxt = S_ACCESS;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_ACCESS: state_nxt = S_RESP;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Capture stage: latch the winner's payload and drive MEMORY during ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_p0   <= OWN_IF;
      last_owner <= OWN_D;
      we_p0      <= 1'b0;
      addr_p0    <= '0;
      wdata_p0   <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
    end else begin
      mem_read  <= take & ~we_nxt;
      mem_write <= take & we_nxt;
      if (take) begin
        owner_p0   <= win_d ? OWN_D : OWN_IF;
        last_owner <= win_d ? OWN_D : OWN_IF;
        we_p0      <= we_nxt;
        addr_p0    <= win_d ? d_addr : if_addr;
        wdata_p0   <= win_d ? d_wdata : '0;
      end
    end
  end

  assign mem_address    = addr_p0;
  assign mem_write_data = wdata_p0;

  // Response stage: memory data lands at the edge ending ACCESS, so read data passes straight through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
    end else begin
      if_done <= (state == S_ACCESS) && (owner_p0 == OWN_IF);
      d_done  <= (state == S_ACCESS) && (owner_p0 == OWN_D);
    end
  end

  assign if_rdata = if_done ? mem_read_data : '0;
  assign d_rdata  = (d_done && !we_p0) ? mem_read_data : '0;
  assign busy     = (state == S_ACCESS) || (state == S_RESP);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a synchronous single-port MEMORY model.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [11:0] if_addr;
  logic        if_gnt, if_done;
  logic [11:0] if_rdata;
  logic        d_req, d_we;
  logic [11:0] d_addr, d_wdata;
  logic        d_gnt, d_done;
  logic [11:0] d_rdata;
  logic        mem_read, mem_write;
  logic [11:0] mem_address, mem_write_data, mem_read_data;
  logic        busy;

  logic        pre_we;
  logic [11:0] pre_addr, pre_data;
  logic [11:0] mem [0:4095];
  logic [11:0] b2b_data [0:3];

  int checks;
  int errors;

  mem_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .if_gnt         (if_gnt),
    .if_done        (if_done),
    .if_rdata       (if_rdata),
    .d_req          (d_req),
    .d_we           (d_we),
    .d_addr         (d_addr),
    .d_wdata        (d_wdata),
    .d_gnt          (d_gnt),
    .d_done         (d_done),
    .d_rdata        (d_rdata),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_write) mem[mem_address] <= mem_write_data;
    if (mem_read) mem_read_data <= mem[mem_address];
  end

  task automatic preload(input logic [11:0] a, input logic [11:0] v);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = v;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    if_req = 1'b1; d_req = 1'b1; if_addr = 12'd0; d_addr = 12'd1000; d_we = 1'b0;
    #1;
    checks++; if (if_gnt !== 1'b0) begin errors++; $display("FAIL rst_if_gnt got %0b exp 0", if_gnt); end
    checks++; if (d_gnt !== 1'b0) begin errors++; $display("FAIL rst_d_gnt got %0b exp 0", d_gnt); end
    checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL rst_mem_ctl got %0b%0b exp 00", mem_read, mem_write); end
    checks++; if (busy !== 1'b0 || if_done !== 1'b0 || d_done !== 1'b0) begin errors++; $display("FAIL rst_busy_done got %0b%0b%0b exp 000", busy, if_done, d_done); end
    checks++; if (mem_address !== 12'd0 || mem_write_data !== 12'd0) begin errors++; $display("FAIL rst_mem_bus got %0h/%0h exp 0/0", mem_address, mem_write_data); end
    rst = 1'b0;
    #1;
    checks++; if (if_gnt !== 1'b1 || d_gnt !== 1'b0) begin errors++; $display("FAIL rst_first_tie got if=%0b d=%0b exp if=1 d=0", if_gnt, d_gnt); end
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0;
    #1;
    checks++; if (busy !== 1'b1 || mem_read !== 1'b1) begin errors++; $display("FAIL rst_access got busy=%0b rd=%0b exp 1/1", busy, mem_read); end
    @(negedge clk); #1;
    checks++; if (if_done !== 1'b1 || d_done !== 1'b0) begin errors++; $display("FAIL rst_done got if=%0b d=%0b exp 1/0", if_done, d_done); end
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0 || d_done !== 1'b0) begin errors++; $display("FAIL rst_withdraw got busy=%0b d_done=%0b exp 0/0", busy, d_done); end
  endtask

  task automatic test_fetch;
    @(negedge clk);
    if_req = 1'b1; if_addr = 12'd0;
    #1;
    checks++; if (if_gnt !== 1'b1 || mem_read !== 1'b0) begin errors++; $display("FAIL fetch_gnt got gnt=%0b rd=%0b exp 1/0", if_gnt, mem_read); end
    @(negedge clk);
    if_req = 1'b0;
    #1;
    checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 12'd0) begin errors++; $display("FAIL fetch_access got rd=%0b wr=%0b a=%0h exp 1/0/0", mem_read, mem_write, mem_address); end
    checks++; if (if_gnt !== 1'b0 || if_done !== 1'b0) begin errors++; $display("FAIL fetch_mid got gnt=%0b done=%0b exp 0/0", if_gnt, if_done); end
    @(negedge clk); #1;
    checks++; if (if_done !== 1'b1 || if_rdata !== 12'o1175) begin errors++; $display("FAIL fetch_done got done=%0b data=%0o exp 1/1175", if_done, if_rdata); end
    checks++; if (mem_read !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL fetch_resp got rd=%0b busy=%0b exp 0/1", mem_read, busy); end
  endtask

  task automatic test_write_read;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 12'd1000; d_wdata = 12'd7;
    #1;
    checks++; if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin errors++; $display("FAIL wr_gnt got d=%0b if=%0b exp 1/0", d_gnt, if_gnt); end
    @(negedge clk);
    d_req = 1'b0;
    #1;
    checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin errors++; $display("FAIL wr_ctl got wr=%0b rd=%0b exp 1/0", mem_write, mem_read); end
    checks++; if (mem_address !== 12'd1000 || mem_write_data !== 12'd7) begin errors++; $display("FAIL wr_bus got a=%0d d=%0d exp 1000/7", mem_address, mem_write_data); end
    @(negedge clk); #1;
    checks++; if (d_done !== 1'b1 || mem_write !== 1'b0) begin errors++; $display("FAIL wr_done got done=%0b wr=%0b exp 1/0", d_done, mem_write); end
    checks++; if (mem[1000] !== 12'd7) begin errors++; $display("FAIL wr_mem got %0d exp 7", mem[1000]); end
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0;
    #1;
    checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL rd_gnt got %0b exp 1", d_gnt); end
    @(negedge clk);
    d_req = 1'b0;
    #1;
    checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0) begin errors++; $display("FAIL rd_ctl got rd=%0b wr=%0b exp 1/0", mem_read, mem_write); end
    @(negedge clk); #1;
    checks++; if (d_done !== 1'b1 || d_rdata !== 12'd7) begin errors++; $display("FAIL rd_done got done=%0b data=%0d exp 1/7", d_done, d_rdata); end
  endtask

  task automatic test_tie;
    logic exp_if;
    if_addr = 12'd0; d_addr = 12'd1000; d_we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if_req = 1'b1; d_req = 1'b1;
      #1;
      exp_if = (i % 2 == 0);
      checks++; if (if_gnt !== exp_if || d_gnt !== !exp_if) begin errors++; $display("FAIL tie_gnt[%0d] got if=%0b d=%0b exp if=%0b", i, if_gnt, d_gnt, exp_if); end
      if (i > 0) begin
        checks++; if (if_done !== !exp_if || d_done !== exp_if) begin errors++; $display("FAIL tie_done[%0d] got if=%0b d=%0b exp if=%0b", i, if_done, d_done, !exp_if); end
        checks++;
        if (exp_if) begin
          if (d_rdata !== 12'd7) begin errors++; $display("FAIL tie_d_rdata[%0d] got %0d exp 7", i, d_rdata); end
        end else begin
          if (if_rdata !== 12'o1175) begin errors++; $display("FAIL tie_if_rdata[%0d] got %0o exp 1175", i, if_rdata); end
        end
      end
      @(negedge clk);
      if (i == 7) begin if_req = 1'b0; d_req = 1'b0; end
      #1;
      checks++; if (if_done !== 1'b0 || d_done !== 1'b0) begin errors++; $display("FAIL tie_access_done[%0d] got if=%0b d=%0b exp 0/0", i, if_done, d_done); end
    end
    @(negedge clk); #1;
    checks++; if (d_done !== 1'b1 || d_rdata !== 12'd7 || if_done !== 1'b0) begin errors++; $display("FAIL tie_last got d=%0b data=%0d if=%0b exp 1/7/0", d_done, d_rdata, if_done); end
    checks++; if (if_gnt !== 1'b0 || d_gnt !== 1'b0) begin errors++; $display("FAIL tie_idle_gnt got if=%0b d=%0b exp 0/0", if_gnt, d_gnt); end
  endtask

  task automatic test_back_to_back;
    b2b_data[0] = 12'd1; b2b_data[1] = 12'd0; b2b_data[2] = 12'd2; b2b_data[3] = 12'd4;
    d_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      d_req = 1'b1; d_addr = 12'(2004 + i);
      #1;
      checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt[%0d] got %0b exp 1", i, d_gnt); end
      if (i > 0) begin
        checks++; if (d_done !== 1'b1 || d_rdata !== b2b_data[i-1]) begin errors++; $display("FAIL b2b_data[%0d] got done=%0b data=%0d exp 1/%0d", i - 1, d_done, d_rdata, b2b_data[i-1]); end
      end
      @(negedge clk);
      if (i == 3) d_req = 1'b0;
      #1;
      checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0 || d_done !== 1'b0) begin errors++; $display("FAIL b2b_access[%0d] got rd=%0b wr=%0b done=%0b exp 1/0/0", i, mem_read, mem_write, d_done); end
    end
    @(negedge clk); #1;
    checks++; if (d_done !== 1'b1 || d_rdata !== 12'd4) begin errors++; $display("FAIL b2b_data[3] got done=%0b data=%0d exp 1/4", d_done, d_rdata); end
  endtask

  task automatic test_abort;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 12'd2000; d_wdata = 12'd5;
    #1;
    checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL abort_gnt got %0b exp 1", d_gnt); end
    @(negedge clk);
    d_req = 1'b0;
    #1;
    checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL abort_pre_wr got %0b exp 1", mem_write); end
    rst = 1'b1;
    #1;
    checks++; if (mem_write !== 1'b0 || busy !== 1'b0 || d_done !== 1'b0) begin errors++; $display("FAIL abort_rst got wr=%0b busy=%0b done=%0b exp 0/0/0", mem_write, busy, d_done); end
    @(negedge clk); #1;
    checks++; if (d_done !== 1'b0) begin errors++; $display("FAIL abort_no_done got %0b exp 0", d_done); end
    checks++; if (mem[2000] !== 12'd0) begin errors++; $display("FAIL abort_mem got %0d exp 0", mem[2000]); end
    rst = 1'b0;
    @(negedge clk); #1;
    checks++; if (d_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_after got done=%0b busy=%0b exp 0/0", d_done, busy); end
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; if_addr = 12'd0;
    #1;
    checks++; if (if_gnt !== 1'b1 || d_gnt !== 1'b0) begin errors++; $display("FAIL abort_tie got if=%0b d=%0b exp 1/0", if_gnt, d_gnt); end
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk); #1;
    checks++; if (if_done !== 1'b1 || if_rdata !== 12'o1175) begin errors++; $display("FAIL abort_fetch got done=%0b data=%0o exp 1/1175", if_done, if_rdata); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    preload(12'd0, 12'o1175);
    preload(12'd1000, 12'd0);
    preload(12'd2000, 12'd0);
    preload(12'd2004, 12'd1);
    preload(12'd2005, 12'd0);
    preload(12'd2006, 12'd2);
    preload(12'd2007, 12'd4);
    test_reset;
    test_fetch;
    test_write_read;
    test_tie;
    test_back_to_back;
    test_abort;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
